// File: rtl/conv_pkg.sv
// Shared types and helpers for the sequential window/kernel dot-product engine.
package conv_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_DONE = 2'd2
  } conv_state_e;

  // Ceiling log2, usable in parameter expressions.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/conv_mac_lane.sv
// LANES parallel multipliers feeding a sum; purely combinational.
module conv_mac_lane #(
  parameter int unsigned LANES  = 3,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 20,
  parameter int unsigned SIGNED = 1
) (
  input  logic [DATA_W-1:0] a_i [LANES],
  input  logic [DATA_W-1:0] b_i [LANES],
  output logic [ACC_W-1:0]  sum_c_o
);

  localparam int unsigned PW = 2 * DATA_W;

  logic [ACC_W-1:0] ext [LANES];

  for (genvar l = 0; l < int'(LANES); l++) begin : g_lane
    if (SIGNED != 0) begin : g_s
      logic signed [PW-1:0] pa;
      logic signed [PW-1:0] pb;
      logic signed [PW-1:0] p;
      assign pa     = PW'($signed(a_i[l]));
      assign pb     = PW'($signed(b_i[l]));
      assign p      = pa * pb;
      assign ext[l] = ACC_W'(p);
    end else begin : g_u
      logic [PW-1:0] p;
      assign p      = PW'(a_i[l]) * PW'(b_i[l]);
      assign ext[l] = ACC_W'(p);
    end
  end

  // ACC_W carries clog2(NTAPS) guard bits, so the reduction cannot overflow.
  always_comb begin
    sum_c_o = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      sum_c_o = sum_c_o + ext[l];
    end
  end

endmodule

// File: rtl/conv_seq.sv
// Sequential KSIZE x KSIZE window-by-kernel dot product, LANES taps per cycle,
// with a full-precision result and a clamped DATA_W copy.
module conv_seq
  import conv_pkg::*;
#(
  parameter  int unsigned KSIZE  = 3,
  parameter  int unsigned DATA_W = 8,
  parameter  int unsigned LANES  = 3,
  parameter  int unsigned SIGNED = 1,
  localparam int unsigned NTAPS  = KSIZE * KSIZE,
  localparam int unsigned NBEATS = (NTAPS + LANES - 1) / LANES,
  localparam int unsigned AW     = clog2(NTAPS),
  localparam int unsigned ACC_W  = 2 * DATA_W + clog2(NTAPS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              kw_en,
  input  logic [AW-1:0]     kw_addr,
  input  logic [DATA_W-1:0] kw_data,
  input  logic              win_valid,
  output logic              win_ready,
  input  logic [DATA_W-1:0] win_data [KSIZE][KSIZE],
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_acc,
  output logic [DATA_W-1:0] res_sat,
  output logic              busy
);

  localparam int unsigned BEAT_W = (NBEATS > 1) ? clog2(NBEATS) : 1;

  localparam logic signed [ACC_W-1:0] SMAX = ACC_W'((64'(1) << (DATA_W - 1)) - 64'(1));
  localparam logic signed [ACC_W-1:0] SMIN = ~SMAX;
  localparam logic        [ACC_W-1:0] UMAX = ACC_W'((64'(1) << DATA_W) - 64'(1));

  conv_state_e         state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [ACC_W-1:0]    res_acc_q, res_acc_d;
  logic [DATA_W-1:0]   res_sat_q, res_sat_d;
  logic                win_ready_q, busy_q, res_valid_q;
  logic [DATA_W-1:0]   kern_q [NTAPS];
  logic [DATA_W-1:0]   win_q  [NTAPS];
  logic [DATA_W-1:0]   lane_a [LANES];
  logic [DATA_W-1:0]   lane_b [LANES];
  logic [ACC_W-1:0]    lane_sum_c;
  logic [ACC_W-1:0]    acc_sum_c;
  logic                load_c;
  logic                kw_we_c;

  function automatic logic [DATA_W-1:0] sat(input logic [ACC_W-1:0] a);
    if (SIGNED != 0) begin
      if ($signed(a) > SMAX)      return DATA_W'(SMAX);
      else if ($signed(a) < SMIN) return DATA_W'(SMIN);
      else                        return DATA_W'(a);
    end else begin
      if (a > UMAX) return DATA_W'(UMAX);
      else          return DATA_W'(a);
    end
  endfunction

  // Operand select for the current beat; taps past NTAPS contribute zero.
  always_comb begin
    for (int l = 0; l < int'(LANES); l++) begin
      lane_a[l] = '0;
      lane_b[l] = '0;
      for (int t = 0; t < int'(NTAPS); t++) begin
        if (t == int'(beat_q) * int'(LANES) + l) begin
          lane_a[l] = win_q[t];
          lane_b[l] = kern_q[t];
        end
      end
    end
  end

  conv_mac_lane #(
    .LANES  (LANES),
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .SIGNED (SIGNED)
  ) u_mac_lane (
    .a_i     (lane_a),
    .b_i     (lane_b),
    .sum_c_o (lane_sum_c)
  );

  assign acc_sum_c = acc_q + lane_sum_c;

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    acc_d     = acc_q;
    res_acc_d = res_acc_q;
    res_sat_d = res_sat_q;
    load_c    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_valid && win_ready_q) begin
          load_c  = 1'b1;
          acc_d   = '0;
          beat_d  = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d  = acc_sum_c;
        beat_d = beat_q + BEAT_W'(1);
        if (beat_q == BEAT_W'(NBEATS - 1)) begin
          res_acc_d = acc_sum_c;
          res_sat_d = sat(acc_sum_c);
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      beat_q      <= '0;
      acc_q       <= '0;
      res_acc_q   <= '0;
      res_sat_q   <= '0;
      win_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      acc_q       <= acc_d;
      res_acc_q   <= res_acc_d;
      res_sat_q   <= res_sat_d;
      win_ready_q <= (state_d == S_IDLE);
      busy_q      <= (state_d == S_MAC);
      res_valid_q <= (state_d == S_DONE);
    end
  end

  // Window snapshot; operands stay fixed for the whole MAC sequence.
  always_ff @(posedge clock) begin
    if (load_c) begin
      for (int t = 0; t < int'(NTAPS); t++) begin
        win_q[t] <= win_data[t / int'(KSIZE)][t % int'(KSIZE)];
      end
    end
  end

  assign kw_we_c = kw_en && (state_q != S_MAC) && (32'(kw_addr) < NTAPS);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int t = 0; t < int'(NTAPS); t++) kern_q[t] <= '0;
    end else if (kw_we_c) begin
      for (int t = 0; t < int'(NTAPS); t++) begin
        if (kw_addr == AW'(t)) kern_q[t] <= kw_data;
      end
    end
  end

  assign win_ready = win_ready_q;
  assign busy      = busy_q;
  assign res_valid = res_valid_q;
  assign res_acc   = res_acc_q;
  assign res_sat   = res_sat_q;

endmodule

// File: doc/conv_seq.md
CONV_SEQ -- requirements
Module: conv_seq

Interface
REQ-001 SHALL have parameter KSIZE, default 3, kernel/window edge length (>=2).
REQ-002 SHALL have parameter DATA_W, default 8, element width.
REQ-003 SHALL have parameter LANES, default 3, multipliers per cycle (1..KSIZE*KSIZE).
REQ-004 SHALL have parameter SIGNED, default 1; 1 = two's-complement operands, 0 = unsigned.
REQ-005 SHALL derive localparams: NTAPS=KSIZE*KSIZE, NBEATS=ceil(NTAPS/LANES), ACC_W=2*DATA_W+clog2(NTAPS).
REQ-006 SHALL have a single clock; reset is synchronous and active-high.
REQ-007 clock  input  1  sole clock, rising edge.
REQ-008 reset  input  1  synchronous, active-high.
REQ-009 kw_en  input  1  kernel tap write strobe.
REQ-010 kw_addr  input  clog2(NTAPS)  tap index, row-major (row*KSIZE+col).
REQ-011 kw_data  input  DATA_W  tap value.
REQ-012 win_valid  input  1  window offered.
REQ-013 win_ready  output  1  window can be accepted.
REQ-014 win_data  input  DATA_W x [KSIZE][KSIZE] unpacked  input window.
REQ-015 res_valid  output  1  result available.
REQ-016 res_ready  input  1  result consumed.
REQ-017 res_acc  output  ACC_W  full-precision dot product.
REQ-018 res_sat  output  DATA_W  res_acc clamped to DATA_W range.
REQ-019 busy  output  1  high in MAC state.

Function
REQ-020 SHALL hold kernel in an internal NTAPS x DATA_W register file; no file-based initialisation.
REQ-021 SHALL write kw_data to tap kw_addr on an edge with kw_en=1 in IDLE or DONE; writes in MAC SHALL be dropped; kw_addr>=NTAPS SHALL be ignored.
REQ-022 SHALL implement FSM IDLE -> MAC -> DONE -> IDLE.
REQ-023 IDLE: win_ready=1; on win_valid&&win_ready, SHALL register the whole window, clear acc, beat=0, go to MAC.
REQ-024 MAC: each cycle SHALL add the LANES products of taps beat*LANES..beat*LANES+LANES-1 to acc; taps >= NTAPS contribute 0.
REQ-025 MAC SHALL go to DONE on the edge processing beat NBEATS-1; res_valid SHALL first be high exactly NBEATS cycles after the accept edge.
REQ-026 DONE: res_valid=1; res_acc/res_sat SHALL stay stable until res_valid&&res_ready, then go to IDLE.
REQ-027 win_ready SHALL be 0 in MAC and DONE (no overlap).
REQ-028 Products SHALL be 2*DATA_W wide, sign-extended (SIGNED=1) or zero-extended (SIGNED=0) to ACC_W; no overflow possible.
REQ-029 res_sat SHALL clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1] when SIGNED=1, else [0, 2^DATA_W-1].
REQ-030 Kernel changes after window accept SHALL NOT affect the in-flight result.

Reset
REQ-031 reset SHALL force IDLE, acc=0, beat=0, all kernel taps=0, res_acc=0, res_sat=0, res_valid=0, busy=0, win_ready=1 in the cycle after release.
REQ-032 reset mid-MAC or mid-DONE SHALL discard the pending result; no res_valid pulse.

Structure
REQ-033 conv_pkg SHALL hold the FSM state enum and a clog2 helper function.
REQ-034 SHALL instantiate one sub-module conv_mac_lane: LANES multiplies plus adder tree, combinational, parameterised by LANES, DATA_W, ACC_W, SIGNED.

Verification
REQ-035 Reset: assert reset 2 cycles -> win_ready=1, res_valid=0, busy=0, res_acc=0.
REQ-036 Defaults, kernel all 1, window 1..9 row-major -> res_acc=45, res_sat=45, res_valid 3 cycles after accept.
REQ-037 Saturation: kernel all 127, window all 127 -> res_acc=145161, res_sat=127; kernel all -128, window all 127 -> res_acc=-146304, res_sat=-128.
REQ-038 Backpressure: res_ready=0 for 5 cycles in DONE -> res_valid, res_acc stable, win_ready=0; res_ready=1 -> IDLE next cycle.
REQ-039 LANES=4 (NBEATS=3, last beat 1 tap), kernel all 1, window 1..9 -> res_acc=45; kw_en in MAC writing tap 0 = 5 -> dropped, next window same 45.
REQ-040 reset asserted in second MAC cycle -> no res_valid, kernel zeroed, next window gives res_acc=0.
